// File: rtl/lsu_access_ctrl_if.sv
// Bundle of AGU-side, data-memory and writeback/exception signals of the LSU
// access controller. The slave modport is the controller itself; the master
// modport is the surrounding pipeline/memory environment.
interface lsu_access_ctrl_if;
    // AGU request side
    logic        agu_valid;
    logic [31:0] agu_pc;
    logic [31:0] agu_addr;
    logic [31:0] agu_store_data;
    logic        agu_is_store;
    logic [3:0]  agu_byte_sel;
    logic        agu_load_unsigned;
    logic [4:0]  agu_rd_addr;
    logic        agu_align_exc;
    logic        flush;
    logic        lsu_ready;
    // data memory port
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    // load writeback
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    // exception report
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_addr;

    modport slave (
        input  agu_valid, agu_pc, agu_addr, agu_store_data, agu_is_store,
               agu_byte_sel, agu_load_unsigned, agu_rd_addr, agu_align_exc,
               flush, dmem_ack, dmem_rdata,
        output lsu_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_rd_addr, wb_data, wb_pc,
               exc_valid, exc_cause, exc_pc, exc_addr
    );

    modport master (
        output agu_valid, agu_pc, agu_addr, agu_store_data, agu_is_store,
               agu_byte_sel, agu_load_unsigned, agu_rd_addr, agu_align_exc,
               flush, dmem_ack, dmem_rdata,
        input  lsu_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
               wb_valid, wb_rd_addr, wb_data, wb_pc,
               exc_valid, exc_cause, exc_pc, exc_addr
    );
endinterface

// File: rtl/lsu_access_ctrl.sv
// LSU access controller: accepts one AGU load/store at a time, issues a single
// data-memory access with lane-shifted data/byte enables, and returns either a
// load writeback or an exception report one cycle after completion.
// Optional feature: define FALCO_LSU_TIMEOUT_EN to add an 8-bit ack-timeout
// counter (limit DMEM_TIMEOUT) that reports a bus timeout (cause 10).
module lsu_access_ctrl #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    lsu_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t      state_reg;
    logic [31:0] pc_reg, addr_reg;
    logic [3:0]  byte_sel_reg;
    logic        unsigned_reg;
    logic [4:0]  rd_reg;
    logic        dmem_req_reg, dmem_we_reg;
    logic [31:0] dmem_addr_reg, dmem_wdata_reg;
    logic [3:0]  dmem_be_reg;
    logic        wb_valid_reg;
    logic [4:0]  wb_rd_addr_reg;
    logic [31:0] wb_data_reg, wb_pc_reg;
    logic        exc_valid_reg;
    logic [1:0]  exc_cause_reg;
    logic [31:0] exc_pc_reg, exc_addr_reg;

    logic        accept;
    logic        timeout_hit;
    logic [31:0] rdata_shifted;
    logic [31:0] load_data;

    // Ready only while idle and not being killed; held low while in reset.
    assign bus.lsu_ready = (state_reg == IDLE) && !bus.flush && !rst;
    assign accept        = bus.agu_valid && bus.lsu_ready;

`ifdef FALCO_LSU_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    // Count cycles spent waiting for ack; idle keeps it cleared so every access starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt_reg <= '0;
        else if (state_reg == IDLE)
            wait_cnt_reg <= '0;
        else
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end

    // Fires in the DMEM_TIMEOUT-th waiting cycle.
    assign timeout_hit = (wait_cnt_reg == 8'(DMEM_TIMEOUT - 1));
`else
    logic unused_timeout_param;
    assign unused_timeout_param = |DMEM_TIMEOUT;
    assign timeout_hit          = 1'b0;
`endif

    // Align the returned word to the access lane, then mask and extend by size.
    always_comb begin
        rdata_shifted = bus.dmem_rdata >> {addr_reg[1:0], 3'b000};
        load_data     = rdata_shifted;
        if (!byte_sel_reg[1])
            load_data = {{24{!unsigned_reg && rdata_shifted[7]}}, rdata_shifted[7:0]};
        else if (!byte_sel_reg[3])
            load_data = {{16{!unsigned_reg && rdata_shifted[15]}}, rdata_shifted[15:0]};
    end

    // Access FSM with registered memory, writeback and exception outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= '0;
            addr_reg       <= '0;
            byte_sel_reg   <= '0;
            unsigned_reg   <= 1'b0;
            rd_reg         <= '0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            dmem_be_reg    <= '0;
            wb_valid_reg   <= 1'b0;
            wb_rd_addr_reg <= '0;
            wb_data_reg    <= '0;
            wb_pc_reg      <= '0;
            exc_valid_reg  <= 1'b0;
            exc_cause_reg  <= '0;
            exc_pc_reg     <= '0;
            exc_addr_reg   <= '0;
        end else begin
            wb_valid_reg  <= 1'b0;
            exc_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (bus.agu_align_exc) begin
                            exc_valid_reg <= 1'b1;
                            exc_cause_reg <= 2'b01;
                            exc_pc_reg    <= bus.agu_pc;
                            exc_addr_reg  <= bus.agu_addr;
                        end else begin
                            state_reg      <= WAIT;
                            pc_reg         <= bus.agu_pc;
                            addr_reg       <= bus.agu_addr;
                            byte_sel_reg   <= bus.agu_byte_sel;
                            unsigned_reg   <= bus.agu_load_unsigned;
                            rd_reg         <= bus.agu_rd_addr;
                            dmem_req_reg   <= 1'b1;
                            dmem_we_reg    <= bus.agu_is_store;
                            dmem_addr_reg  <= {bus.agu_addr[31:2], 2'b00};
                            dmem_be_reg    <= bus.agu_byte_sel << bus.agu_addr[1:0];
                            dmem_wdata_reg <= bus.agu_store_data << {bus.agu_addr[1:0], 3'b000};
                        end
                    end
                end
                WAIT: begin
                    if (bus.dmem_ack || timeout_hit) begin
                        state_reg      <= IDLE;
                        dmem_req_reg   <= 1'b0;
                        dmem_we_reg    <= 1'b0;
                        dmem_be_reg    <= '0;
                        dmem_addr_reg  <= '0;
                        dmem_wdata_reg <= '0;
                        // A simultaneous flush wins: the result is dropped.
                        if (bus.dmem_ack && !bus.flush && !dmem_we_reg) begin
                            wb_valid_reg   <= 1'b1;
                            wb_rd_addr_reg <= rd_reg;
                            wb_data_reg    <= load_data;
                            wb_pc_reg      <= pc_reg;
                        end else if (!bus.dmem_ack && !bus.flush) begin
                            exc_valid_reg <= 1'b1;
                            exc_cause_reg <= 2'b10;
                            exc_pc_reg    <= pc_reg;
                            exc_addr_reg  <= addr_reg;
                        end
                    end else if (bus.flush) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Killed access: keep the request up until memory finishes, report nothing.
                    if (bus.dmem_ack || timeout_hit) begin
                        state_reg      <= IDLE;
                        dmem_req_reg   <= 1'b0;
                        dmem_we_reg    <= 1'b0;
                        dmem_be_reg    <= '0;
                        dmem_addr_reg  <= '0;
                        dmem_wdata_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.dmem_req   = dmem_req_reg;
    assign bus.dmem_we    = dmem_we_reg;
    assign bus.dmem_addr  = dmem_addr_reg;
    assign bus.dmem_wdata = dmem_wdata_reg;
    assign bus.dmem_be    = dmem_be_reg;
    // A kill arriving in the pulse cycle cancels the pending writeback/exception.
    assign bus.wb_valid   = wb_valid_reg && !bus.flush;
    assign bus.wb_rd_addr = wb_rd_addr_reg;
    assign bus.wb_data    = wb_data_reg;
    assign bus.wb_pc      = wb_pc_reg;
    assign bus.exc_valid  = exc_valid_reg && !bus.flush;
    assign bus.exc_cause  = exc_cause_reg;
    assign bus.exc_pc     = exc_pc_reg;
    assign bus.exc_addr   = exc_addr_reg;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed self-checking bench for lsu_access_ctrl.
module tb_lsu_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lsu_access_ctrl_if bus ();

    lsu_access_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present one AGU instruction for a single accepted cycle.
    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic st, input logic [3:0] bs, input logic uns,
                         input logic [4:0] rd, input logic aexc);
        bus.agu_pc = pc; bus.agu_addr = addr; bus.agu_store_data = sdata;
        bus.agu_is_store = st; bus.agu_byte_sel = bs; bus.agu_load_unsigned = uns;
        bus.agu_rd_addr = rd; bus.agu_align_exc = aexc; bus.agu_valid = 1'b1;
        step();
        bus.agu_valid = 1'b0; bus.agu_align_exc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.lsu_ready); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.exc_valid !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", bus.exc_valid); end
        checks++; if (bus.dmem_be !== 4'b0000) begin errors++; $display("FAIL reset_be: got %b expected 0000", bus.dmem_be); end
        $display("reset released");
    endtask

    task automatic test_load_byte();
        issue(32'h0000_0100, 32'h0000_1003, 32'h0, 1'b0, 4'b0001, 1'b0, 5'd7, 1'b0);
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.dmem_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b expected 1000", bus.dmem_be); end
        checks++; if (bus.dmem_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h expected 00001000", bus.dmem_addr); end
        checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b expected 0", bus.dmem_we); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL lb_ready_wait: got %b expected 0", bus.lsu_ready); end
        step();
        step();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FF_FFFF;
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL lb_req_ack: got %b expected 1", bus.dmem_req); end
        step();
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL lb_wb_valid: got %b expected 1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data: got %h expected ffffff80", bus.wb_data); end
        checks++; if (bus.wb_rd_addr !== 5'd7) begin errors++; $display("FAIL lb_wb_rd: got %0d expected 7", bus.wb_rd_addr); end
        checks++; if (bus.wb_pc !== 32'h0000_0100) begin errors++; $display("FAIL lb_wb_pc: got %h expected 00000100", bus.wb_pc); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b expected 0", bus.dmem_req); end
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wb_pulse: got %b expected 0", bus.wb_valid); end
        $display("load byte addr=00001003 wb_data=%h", bus.wb_data);
    endtask

    task automatic test_store_half();
        issue(32'h0000_0104, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0);
        checks++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b expected 1", bus.dmem_we); end
        checks++; if (bus.dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", bus.dmem_be); end
        checks++; if (bus.dmem_wdata !== 32'hBEEF_0000) begin errors++; $display("FAIL sh_wdata: got %h expected beef0000", bus.dmem_wdata); end
        checks++; if (bus.dmem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h expected 00002000", bus.dmem_addr); end
        bus.dmem_ack = 1'b1;
        step();
        bus.dmem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL sh_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL sh_req_drop: got %b expected 0", bus.dmem_req); end
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL sh_ready: got %b expected 1", bus.lsu_ready); end
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL sh_wb_late: got %b expected 0", bus.wb_valid); end
        $display("store half addr=00002002 wdata=beef0000");
    endtask

    task automatic test_align_exc();
        issue(32'h0000_0040, 32'h0000_1001, 32'h0, 1'b0, 4'b0011, 1'b0, 5'd3, 1'b1);
        checks++; if (bus.exc_valid !== 1'b1) begin errors++; $display("FAIL ae_valid: got %b expected 1", bus.exc_valid); end
        checks++; if (bus.exc_cause !== 2'b01) begin errors++; $display("FAIL ae_cause: got %b expected 01", bus.exc_cause); end
        checks++; if (bus.exc_pc !== 32'h0000_0040) begin errors++; $display("FAIL ae_pc: got %h expected 00000040", bus.exc_pc); end
        checks++; if (bus.exc_addr !== 32'h0000_1001) begin errors++; $display("FAIL ae_addr: got %h expected 00001001", bus.exc_addr); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ae_req: got %b expected 0", bus.dmem_req); end
        step();
        checks++; if (bus.exc_valid !== 1'b0) begin errors++; $display("FAIL ae_pulse: got %b expected 0", bus.exc_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ae_req_late: got %b expected 0", bus.dmem_req); end
        $display("misaligned pc=00000040 addr=00001001 cause=01");
    endtask

    task automatic test_load_variants();
        logic [31:0] v_addr [3] = '{32'h0000_1002, 32'h0000_0010, 32'h0000_1001};
        logic [3:0]  v_bs   [3] = '{4'b0011, 4'b1111, 4'b0001};
        logic        v_uns  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] v_rd   [3] = '{32'h8001_1234, 32'hDEAD_BEEF, 32'h0000_A500};
        logic [31:0] v_exp  [3] = '{32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_00A5};
        for (int i = 0; i < 3; i++) begin
            issue(32'h0000_0200 + 32'(i), v_addr[i], 32'h0, 1'b0, v_bs[i], v_uns[i], 5'd9, 1'b0);
            bus.dmem_ack = 1'b1; bus.dmem_rdata = v_rd[i];
            step();
            bus.dmem_ack = 1'b0;
            checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL lv%0d_wb_valid: got %b expected 1", i, bus.wb_valid); end
            checks++; if (bus.wb_data !== v_exp[i]) begin errors++; $display("FAIL lv%0d_wb_data: got %h expected %h", i, bus.wb_data, v_exp[i]); end
            $display("load variant %0d addr=%h wb_data=%h", i, v_addr[i], bus.wb_data);
            step();
        end
    endtask

    task automatic test_flush_wait();
        issue(32'h0000_0300, 32'h0000_3000, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd4, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL fw_req_drain: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL fw_ready_drain: got %b expected 0", bus.lsu_ready); end
        step();
        step();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL fw_req_held: got %b expected 1", bus.dmem_req); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
        step();
        bus.dmem_ack = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fw_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL fw_req_drop: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL fw_ready: got %b expected 1", bus.lsu_ready); end
        step();
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fw_wb_late: got %b expected 0", bus.wb_valid); end
        $display("flushed load addr=00003000 drained");
    endtask

    task automatic test_ack_flush_same();
        issue(32'h0000_0400, 32'h0000_4000, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd5, 1'b0);
        bus.dmem_ack = 1'b1; bus.flush = 1'b1; bus.dmem_rdata = 32'hCAFE_F00D;
        step();
        bus.dmem_ack = 1'b0; bus.flush = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL af_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL af_req: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL af_ready: got %b expected 1", bus.lsu_ready); end
        $display("ack+flush same cycle addr=00004000 discarded");
        step();
    endtask

    task automatic test_flush_idle();
        issue(32'h0000_0500, 32'h0000_5000, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd6, 1'b0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_0001;
        step();
        bus.dmem_ack = 1'b0;
        // pulse is pending this cycle; kill it and also offer a new instruction
        bus.flush = 1'b1; bus.agu_valid = 1'b1; bus.agu_addr = 32'h0000_6000; bus.agu_align_exc = 1'b0;
        #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fi_wb_cancel: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL fi_ready: got %b expected 0", bus.lsu_ready); end
        step();
        bus.flush = 1'b0; bus.agu_valid = 1'b0;
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL fi_no_accept: got %b expected 0", bus.dmem_req); end
        $display("flush in idle blocked accept and cancelled writeback");
    endtask

    task automatic test_ack_idle();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        step();
        bus.dmem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ai_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ai_req: got %b expected 0", bus.dmem_req); end
        $display("stray ack in idle ignored");
    endtask

    task automatic test_reset_mid_wait();
        issue(32'h0000_0600, 32'h0000_7000, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd8, 1'b0);
        rst = 1'b1;
        #1;
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL rw_addr: got %h expected 00000000", bus.dmem_addr); end
        step();
        rst = 1'b0;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
        step();
        bus.dmem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rw_wb: got %b expected 0", bus.wb_valid); end
        checks++; if (bus.exc_valid !== 1'b0) begin errors++; $display("FAIL rw_exc: got %b expected 0", bus.exc_valid); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b expected 1", bus.lsu_ready); end
        issue(32'h0000_0604, 32'h0000_7004, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd10, 1'b0);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BAD_CAFE;
        step();
        bus.dmem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rw_next_wb: got %b expected 1", bus.wb_valid); end
        checks++; if (bus.wb_data !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rw_next_data: got %h expected 0badcafe", bus.wb_data); end
        $display("reset mid-wait, next load wb_data=%h", bus.wb_data);
        step();
    endtask

    task automatic test_timeout();
        issue(32'h0000_0700, 32'h0000_8000, 32'h0, 1'b0, 4'b1111, 1'b0, 5'd11, 1'b0);
        repeat (3) step();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL to_req_w4: got %b expected 1", bus.dmem_req); end
        step();
`ifdef FALCO_LSU_TIMEOUT_EN
        checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b expected 0", bus.dmem_req); end
        checks++; if (bus.exc_valid !== 1'b1) begin errors++; $display("FAIL to_exc: got %b expected 1", bus.exc_valid); end
        checks++; if (bus.exc_cause !== 2'b10) begin errors++; $display("FAIL to_cause: got %b expected 10", bus.exc_cause); end
        checks++; if (bus.exc_addr !== 32'h0000_8000) begin errors++; $display("FAIL to_addr: got %h expected 00008000", bus.exc_addr); end
        $display("timeout addr=00008000 cause=%b", bus.exc_cause);
        step();
`else
        repeat (6) step();
        checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL to_stay_req: got %b expected 1", bus.dmem_req); end
        checks++; if (bus.exc_valid !== 1'b0) begin errors++; $display("FAIL to_no_exc: got %b expected 0", bus.exc_valid); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL to_stay_wait: got %b expected 0", bus.lsu_ready); end
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0000_0042;
        step();
        bus.dmem_ack = 1'b0;
        checks++; if (bus.wb_data !== 32'h0000_0042) begin errors++; $display("FAIL to_late_data: got %h expected 00000042", bus.wb_data); end
        $display("no timeout: load waited, wb_data=%h", bus.wb_data);
        step();
`endif
    endtask

    initial begin
        bus.agu_valid = 1'b0; bus.agu_pc = '0; bus.agu_addr = '0; bus.agu_store_data = '0;
        bus.agu_is_store = 1'b0; bus.agu_byte_sel = '0; bus.agu_load_unsigned = 1'b0;
        bus.agu_rd_addr = '0; bus.agu_align_exc = 1'b0; bus.flush = 1'b0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        test_reset();
        test_load_byte();
        test_store_half();
        test_align_exc();
        test_load_variants();
        test_flush_wait();
        test_ack_flush_same();
        test_flush_idle();
        test_ack_idle();
        test_reset_mid_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
